multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Multicycle main controller for the single-datapath MIPS core. Sequences fetch/decode/execute/memory/writeback
//  over one unified memory port (mem_req/mem_ready handshake) and drives every datapath control strobe.
//  Datapath PC register gains an enable (pc_en); IR loads from memory readdata on ir_load.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles mem_req may stay high without mem_ready before entering FAULT (>=1)
// PORTS
//  clk            in   1  clock; all state on posedge
//  reset          in   1  synchronous, active-high
//  op             in   6  instr[31:26] (from IR)
//  funct          in   6  instr[5:0]
//  zero           in   1  ALU zero flag
//  mem_ready      in   1  memory completes current request this cycle
//  mem_req        out  1  memory request, held until mem_ready
//  mem_we         out  1  write request (valid with mem_req)
//  mem_addr_sel   out  1  0 = pc, 1 = aluout
//  ir_load        out  1  load IR from readdata
//  pc_en          out  1  PC <= nextpc this cycle
//  jump/dobranch  out  1  each; datapath nextpc selects
//  alusrcbimm     out  1  ALU B = sign-extended imm
//  destreg_sel    out  1  0 = rt (instr[20:16]), 1 = rd (instr[15:11])
//  regwrite       out  1  register file write enable
//  memtoreg       out  1  writeback selects readdata
//  alucontrol     out  3  000 and, 001 or, 010 add, 110 sub, 100 lui, 011 ori, 111 slt
//  instr_retired  out  1  one-cycle pulse, equals pc_en
//  illegal_instr  out  1  one-cycle pulse on unknown op/funct
//  fault          out  1  sticky memory-timeout flag
//  state          out  3  FETCH 0, DECODE 1, EXECUTE 2, MEMRD 3, MEMWR 4, WRITEBACK 5, FAULT 7
// BEHAVIOUR
//  Reset: state=FETCH, fault=0, wait counter=0. All strobes 0; alucontrol=010 during reset cycle and outside EXECUTE/MEM/WB.
//  Decoded class latched in DECODE, held until return to FETCH. Class drives alucontrol/alusrcbimm/destreg_sel from EXECUTE on.
//  Supported: R-type op 000000 (funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); lw 100011;
//  sw 101011; beq 000100; addi 001000; ori 001101; lui 001111; j 000010. Anything else = illegal.
//  FETCH: mem_req=1, we=0, addr_sel=0. On mem_ready: ir_load=1, go DECODE.
//  DECODE: 1 cycle. Illegal: illegal_instr=1, pc_en=1 (skip), go FETCH. j: jump=1, pc_en=1, go FETCH. Else go EXECUTE.
//  EXECUTE: 1 cycle. R/addi/ori/lui -> WRITEBACK. lw -> MEMRD. sw -> MEMWR.
//           beq: dobranch=zero, pc_en=1, go FETCH.
//  MEMRD: mem_req=1, addr_sel=1. On mem_ready: regwrite=1, memtoreg=1, destreg_sel=0, pc_en=1, go FETCH.
//  MEMWR: mem_req=1, mem_we=1, addr_sel=1. On mem_ready: pc_en=1, go FETCH.
//  WRITEBACK: regwrite=1, destreg_sel=1 for R-type else 0, pc_en=1, go FETCH.
//  Latency with zero-wait memory: R/I-ALU 4, lw 4, sw 4, beq 3, j 2, illegal 2 cycles.
//  Handshake: mem_req never drops before mem_ready; mem_ready ignored when mem_req=0; mem_ready same cycle as
//   mem_req rise completes it (0-wait).
//  Timeout: counter clears on entry to FETCH/MEMRD/MEMWR, +1 per cycle with mem_req & !mem_ready.
//   Reaching MEM_TIMEOUT -> FAULT: fault=1, all strobes 0, held until reset. mem_ready on the cycle the count reaches MEM_TIMEOUT wins.
//  regwrite, pc_en, ir_load, mem_we never asserted in the same cycle as FAULT or reset.
//  Reset mid-instruction: aborts, no pc_en/regwrite, next cycle FETCH at datapath reset PC.
// TESTING
//  1 Reset, mem_ready=1 always, add (op 0, funct 100000) -> states 0,1,2,5; regwrite+destreg_sel=1 cycle 4; pc_en once.
//  2 lw with mem_ready delayed 3 cycles in MEMRD -> mem_req,addr_sel=1 held 4 cycles; regwrite+memtoreg only on ready cycle.
//  3 beq with zero=1 then zero=0 -> dobranch=1/0 in EXECUTE, pc_en=1 both, 3 cycles each, no regwrite.
//  4 j then op 111111 -> jump=1+pc_en in DECODE; illegal_instr=1 pulse, pc_en=1, no regwrite.
//  5 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 4 waits, fault=1 sticky; reset returns to FETCH, fault=0.
//  6 Assert reset in MEMWR mid-wait -> no mem_we after reset; next state FETCH; sw not retired.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback over one
// shared memory port and drives the datapath control strobes, with a memory-timeout fault trap.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_load,
    output logic       pc_en,
    output logic       jump,
    output logic       dobranch,
    output logic       alusrcbimm,
    output logic       destreg_sel,
    output logic       regwrite,
    output logic       memtoreg,
    output logic [2:0] alucontrol,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic       fault,
    output logic [2:0] state
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEMRD = 3'd3;
    localparam logic [2:0] S_MEMWR = 3'd4;
    localparam logic [2:0] S_WB = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd7;

    localparam logic [2:0] C_R = 3'd0;
    localparam logic [2:0] C_LW = 3'd1;
    localparam logic [2:0] C_SW = 3'd2;
    localparam logic [2:0] C_BEQ = 3'd3;
    localparam logic [2:0] C_ADDI = 3'd4;
    localparam logic [2:0] C_ORI = 3'd5;
    localparam logic [2:0] C_LUI = 3'd6;
    localparam logic [2:0] C_J = 3'd7;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_LUI = 3'b100;
    localparam logic [2:0] ALU_ORI = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [2:0]    state_q, state_d;
    logic [2:0]    cls_q, cls_d;
    logic [2:0]    alu_q, alu_d;
    logic          fault_q, fault_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [2:0] dec_cls;
    logic [2:0] dec_alu;
    logic       dec_ill;
    logic       req_state;
    logic       mem_wait;

    always_comb begin
        dec_cls = C_R;
        dec_alu = ALU_ADD;
        dec_ill = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100000: dec_alu = ALU_ADD;
                    6'b100010: dec_alu = ALU_SUB;
                    6'b100100: dec_alu = ALU_AND;
                    6'b100101: dec_alu = ALU_OR;
                    6'b101010: dec_alu = ALU_SLT;
                    default:   dec_ill = 1'b1;
                endcase
            end
            6'b100011: dec_cls = C_LW;
            6'b101011: dec_cls = C_SW;
            6'b000100: begin dec_cls = C_BEQ; dec_alu = ALU_SUB; end
            6'b001000: dec_cls = C_ADDI;
            6'b001101: begin dec_cls = C_ORI; dec_alu = ALU_ORI; end
            6'b001111: begin dec_cls = C_LUI; dec_alu = ALU_LUI; end
            6'b000010: dec_cls = C_J;
            default:   dec_ill = 1'b1;
        endcase
    end

    assign req_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign mem_wait  = req_state && !mem_ready;

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        alu_d   = alu_q;
        fault_d = fault_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                cls_d = dec_cls;
                alu_d = dec_alu;
                state_d = (dec_ill || dec_cls == C_J) ? S_FETCH : S_EXECUTE;
            end
            S_EXECUTE: begin
                case (cls_q)
                    C_LW:    state_d = S_MEMRD;
                    C_SW:    state_d = S_MEMWR;
                    C_BEQ:   state_d = S_FETCH;
                    default: state_d = S_WB;
                endcase
            end
            S_MEMRD, S_MEMWR: if (mem_ready) state_d = S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FETCH;
        endcase
        // A ready on the final allowed wait cycle completes normally; only a miss traps.
        if (mem_wait && cnt_q == CW'(MEM_TIMEOUT - 1)) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
        end
        if (state_d != state_q)
            cnt_d = '0;
        else if (mem_wait)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= C_R;
            alu_q   <= ALU_ADD;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            alu_q   <= alu_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes are gated by reset so an aborted instruction never writes or retires.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_load       = 1'b0;
        pc_en         = 1'b0;
        jump          = 1'b0;
        dobranch      = 1'b0;
        alusrcbimm    = 1'b0;
        destreg_sel   = 1'b0;
        regwrite      = 1'b0;
        memtoreg      = 1'b0;
        alucontrol    = ALU_ADD;
        illegal_instr = 1'b0;
        if (!reset) begin
            if (state_q == S_EXECUTE || state_q == S_MEMRD || state_q == S_MEMWR || state_q == S_WB) begin
                alucontrol  = alu_q;
                alusrcbimm  = (cls_q == C_LW) || (cls_q == C_SW) || (cls_q == C_ADDI) ||
                              (cls_q == C_ORI) || (cls_q == C_LUI);
                destreg_sel = (cls_q == C_R);
            end
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_load = mem_ready;
                end
                S_DECODE: begin
                    illegal_instr = dec_ill;
                    jump          = !dec_ill && (dec_cls == C_J);
                    pc_en         = dec_ill || (dec_cls == C_J);
                end
                S_EXECUTE: begin
                    dobranch = (cls_q == C_BEQ) && zero;
                    pc_en    = (cls_q == C_BEQ);
                end
                S_MEMRD: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    destreg_sel  = 1'b0;
                    regwrite     = mem_ready;
                    memtoreg     = mem_ready;
                    pc_en        = mem_ready;
                end
                S_MEMWR: begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_sel = 1'b1;
                    pc_en        = mem_ready;
                end
                S_WB: begin
                    regwrite = 1'b1;
                    pc_en    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instr_retired = pc_en;
    assign fault         = fault_q;
    assign state         = state_q;

endmodule
